stall_ctrl: RTL

- Central hazard sequencer for the in-order front end (PIF, IFID, ID) ahead of the out-of-order back end (ROB/RS).
- Tracks ROB occupancy and drives the full-stall condition.
- Runs the jump-stall protocol: stall on issue of a possible jump, hold until WB commits it, then redirect PC and insert one extra IFID bubble for the stale IFID contents.
- Centralises the stall/reset/jump handshake that ID and WB currently handle between them.

---
 rtl/stall_ctrl_if.sv | 34 +++
 rtl/stall_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/stall_ctrl_if.sv
// Front-end hazard bus between ID/WB producers and the PIF/IFID consumers.
// The master side drives issue/commit events; the slave side (stall_ctrl)
// returns the stall, redirect and occupancy outputs.
interface stall_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 5
);
  logic              id_issue_valid;
  logic              id_is_jump;
  logic              wb_commit_valid;
  logic              wb_is_jump;
  logic              wb_jump_taken;
  logic [ADDR_W-1:0] wb_jump_addr;
  logic              pif_stall;
  logic              pif_jump_en;
  logic [ADDR_W-1:0] pif_jump_addr;
  logic              ifid_nop;
  logic              full_stall;
  logic [CNT_W-1:0]  rob_count;

  modport master (
    output id_issue_valid, id_is_jump, wb_commit_valid, wb_is_jump,
           wb_jump_taken, wb_jump_addr,
    input  pif_stall, pif_jump_en, pif_jump_addr, ifid_nop, full_stall,
           rob_count
  );

  modport slave (
    input  id_issue_valid, id_is_jump, wb_commit_valid, wb_is_jump,
           wb_jump_taken, wb_jump_addr,
    output pif_stall, pif_jump_en, pif_jump_addr, ifid_nop, full_stall,
           rob_count
  );
endinterface

// File: rtl/stall_ctrl.sv
// Central hazard sequencer for the in-order front end.
// Tracks ROB occupancy (full stall) and runs the jump-stall protocol:
// stall after a possible jump issues, hold until WB commits it, then
// redirect the PC and give IFID one extra bubble for its stale contents.
module stall_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int CNT_W     = 5,
  parameter int ADDR_W    = 32
) (
  input logic        clk,
  input logic        rst_n,
  stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    JSTALL = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  count_q;
  logic              jump_en_q;
  logic [ADDR_W-1:0] jump_addr_q;
  logic              full;
  logic              issue_acc;
  logic              commit_cnt;
  logic              jump_commit;
  logic              stall_o;
  logic              nop_o;

  // Issue is only taken while running with room in the ROB; a commit only
  // counts when there is something to retire, so the counter cannot wrap.
  assign full        = (count_q == CNT_W'(ROB_DEPTH));
  assign issue_acc   = bus.id_issue_valid && !full && (state_q == RUN);
  assign commit_cnt  = bus.wb_commit_valid && (count_q != '0);
  assign jump_commit = bus.wb_commit_valid && bus.wb_is_jump;

  // State register; reset abandons any stall without a redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stall/bubble decode from the registered state.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    nop_o   = 1'b0;
    case (state_q)
      RUN: begin
        if (issue_acc && bus.id_is_jump) begin
          state_d = JSTALL;
        end
      end
      JSTALL: begin
        stall_o = 1'b1;
        nop_o   = 1'b1;
        if (jump_commit) begin
          state_d = BUBBLE;
        end
      end
      BUBBLE: begin
        nop_o   = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // ROB occupancy: simultaneous issue and commit cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (issue_acc && !commit_cnt) begin
      count_q <= count_q + CNT_W'(1);
    end else if (!issue_acc && commit_cnt) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Redirect capture: strobe lives for the bubble cycle only, target is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      jump_en_q <= 1'b0;
      if ((state_q == JSTALL) && jump_commit) begin
        jump_en_q   <= bus.wb_jump_taken;
        jump_addr_q <= bus.wb_jump_addr;
      end
    end
  end

  assign bus.pif_stall     = stall_o;
  assign bus.ifid_nop      = nop_o;
  assign bus.pif_jump_en   = jump_en_q;
  assign bus.pif_jump_addr = jump_addr_q;
  assign bus.full_stall    = full;
  assign bus.rob_count     = count_q;

  // A jump can only retire while the front end is waiting on it.
  jump_commit_in_jstall: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(jump_commit && (state_q != JSTALL))
  );

endmodule
